// File: rtl/ov7670_capture_multi.sv
// OV7670 byte-stream capture: packs RGB444 / RGB565 / Y8 pixels with optional 2x/4x subsampling into a bounded frame buffer.
// Define OV_FRAME_STATS_EN to add per-frame pix_count / line_count outputs.
module ov7670_capture_multi #(
    parameter int ADDR_W   = 17,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MAX_PIX  = 76800
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic [1:0]        mode,
    input  logic [1:0]        decim,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              overflow
`ifdef OV_FRAME_STATS_EN
    ,
    output logic [ADDR_W-1:0] pix_count,
    output logic [9:0]        line_count
`endif
);

    // Counters need at least two bits so the 4x subsample test on the low bits is always valid.
    localparam int CW = ($clog2(H_ACTIVE) < 2) ? 2 : $clog2(H_ACTIVE);
    localparam int RW = ($clog2(V_ACTIVE + 1) < 2) ? 2 : $clog2(V_ACTIVE + 1);
    localparam logic [CW-1:0]   COL_LAST   = CW'(H_ACTIVE - 1);
    localparam logic [RW-1:0]   ROW_END    = RW'(V_ACTIVE);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MAX_PIX);

    localparam logic [1:0] WAIT_VS = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]    state;
    logic          vs_q, vs_q2, hr_q, hr_q2;
    logic [7:0]    d_q;
    logic [7:0]    b0;
    logic          phase;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          line_full;
    logic [1:0]    mode_q;
    logic [1:0]    decim_q;

    logic          vs_fall, vs_rise, hr_fall;
    logic [1:0]    step_mask;
    logic          keep;
    logic          room;
    logic [15:0]   pix_data;

`ifdef OV_FRAME_STATS_EN
    logic [ADDR_W-1:0] pix_cnt;
    logic [9:0]        line_cnt;
`endif

    assign vs_fall = vs_q2 & ~vs_q;
    assign vs_rise = ~vs_q2 & vs_q;
    assign hr_fall = hr_q2 & ~hr_q;

    always_comb begin
        step_mask = 2'b11;
        case (decim_q)
            2'd0:    step_mask = 2'b00;
            2'd1:    step_mask = 2'b01;
            default: step_mask = 2'b11;
        endcase
    end

    // A pixel is kept only inside the active window and on the subsample grid.
    assign keep = ((col[1:0] & step_mask) == 2'b00) &&
                  ((row[1:0] & step_mask) == 2'b00) &&
                  !line_full && (row < ROW_END);
    assign room = ({1'b0, addr} < ADDR_LIMIT);

    always_comb begin
        pix_data = {4'h0, b0[7:4], b0[2:0], d_q[7], d_q[4:1]};
        case (mode_q)
            2'd1:    pix_data = {b0, d_q};
            2'd2:    pix_data = {8'h00, b0};
            default: pix_data = {4'h0, b0[7:4], b0[2:0], d_q[7], d_q[4:1]};
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= WAIT_VS;
            vs_q       <= 1'b0;
            vs_q2      <= 1'b0;
            hr_q       <= 1'b0;
            hr_q2      <= 1'b0;
            d_q        <= 8'h00;
            b0         <= 8'h00;
            phase      <= 1'b0;
            col        <= '0;
            row        <= '0;
            line_full  <= 1'b0;
            mode_q     <= 2'd0;
            decim_q    <= 2'd0;
            addr       <= '0;
            dout       <= 16'h0000;
            we         <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
`ifdef OV_FRAME_STATS_EN
            pix_cnt    <= '0;
            line_cnt   <= 10'd0;
            pix_count  <= '0;
            line_count <= 10'd0;
`endif
        end else begin
            vs_q       <= vsync;
            vs_q2      <= vs_q;
            hr_q       <= href;
            hr_q2      <= hr_q;
            d_q        <= d;
            we         <= 1'b0;
            frame_done <= 1'b0;

            if (we) begin
                addr <= addr + ADDR_W'(1);
            end
`ifdef OV_FRAME_STATS_EN
            if (we) begin
                pix_cnt <= pix_cnt + ADDR_W'(1);
            end
`endif

            case (state)
                WAIT_VS: begin
                    phase     <= 1'b0;
                    col       <= '0;
                    line_full <= 1'b0;
                    if (vs_fall) begin
                        mode_q   <= mode;
                        decim_q  <= decim;
                        addr     <= '0;
                        row      <= '0;
                        overflow <= 1'b0;
                        state    <= ACTIVE;
`ifdef OV_FRAME_STATS_EN
                        pix_cnt  <= '0;
                        line_cnt <= 10'd0;
`endif
                    end
                end

                ACTIVE: begin
                    if (hr_q) begin
                        phase <= ~phase;
                        if (!phase) begin
                            b0 <= d_q;
                        end else begin
                            // A suppressed store leaves addr untouched so the buffer never wraps.
                            if (keep) begin
                                if (room) begin
                                    we   <= 1'b1;
                                    dout <= pix_data;
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end
                            if (col == COL_LAST) begin
                                line_full <= 1'b1;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    if (hr_fall) begin
                        phase     <= 1'b0;
                        col       <= '0;
                        line_full <= 1'b0;
                        if (row != ROW_END) begin
                            row <= row + RW'(1);
                        end
`ifdef OV_FRAME_STATS_EN
                        line_cnt <= line_cnt + 10'd1;
`endif
                    end
                    if (vs_rise) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    frame_done <= 1'b1;
                    state      <= WAIT_VS;
`ifdef OV_FRAME_STATS_EN
                    pix_count  <= pix_cnt + ADDR_W'(we);
                    line_count <= line_cnt;
`endif
                end

                default: begin
                    state <= WAIT_VS;
                end
            endcase
        end
    end

endmodule
